adder_8bits_accum: RTL

- Downstream consumer of the 8-bit adder stage. Each handshake beat takes one adder result ({carry, sum}, 9 bits).
- Accumulates BEATS results into a wide running total, then presents the total on a valid/ready output port.
- Turns the combinational adder into a multi-operand summing pipeline stage.

---
 rtl/adder_8bits_accum_pkg.sv | 17 +
 rtl/adder_8bits_accum_if.sv | 35 +++
 rtl/adder_8bits_accum_add_sat.sv | 28 ++
 rtl/adder_8bits_accum.sv | 103 ++++++++++
 4 files changed

// File: rtl/adder_8bits_accum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accum_pkg : shared types and widths for the adder result accumulator |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package accum_pkg;

  localparam int ADDER_W = 8;
  localparam int BEAT_W  = ADDER_W + 1;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/adder_8bits_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_8bits_accum_if : beat input, result output and status bundle   |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface adder_8bits_accum_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) ();
  import accum_pkg::*;

  logic               Acc_clear;
  logic               Acc_in_valid;
  logic               Acc_in_ready;
  logic [ADDER_W-1:0] Acc_in_sum;
  logic               Acc_in_cout;
  logic               Acc_out_valid;
  logic               Acc_out_ready;
  logic [ACC_W-1:0]   Acc_out_data;
  logic               Acc_out_ovf;
  logic [CNT_W-1:0]   Acc_count;

  // master drives beats and consumes results; slave is the accumulator
  modport master (
    output Acc_clear, Acc_in_valid, Acc_in_sum, Acc_in_cout, Acc_out_ready,
    input  Acc_in_ready, Acc_out_valid, Acc_out_data, Acc_out_ovf, Acc_count
  );

  modport slave (
    input  Acc_clear, Acc_in_valid, Acc_in_sum, Acc_in_cout, Acc_out_ready,
    output Acc_in_ready, Acc_out_valid, Acc_out_data, Acc_out_ovf, Acc_count
  );

endinterface
`default_nettype wire

// File: rtl/adder_8bits_accum_add_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_add_sat : ACC_W unsigned adder with carry-out; clamps to all-ones|
// |               on carry when ACC_SATURATE_EN is defined.  Rev 1.0     |
// +----------------------------------------------------------------------+
module acc_add_sat #(
  parameter int ACC_W = 16
) (
  input  wire logic [ACC_W-1:0] i_a,
  input  wire logic [ACC_W-1:0] i_b,
  output logic      [ACC_W-1:0] o_sum,
  output logic                  o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[ACC_W];

`ifdef ACC_SATURATE_EN
  // once clamped, any further non-zero beat carries again and stays clamped
  assign o_sum = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/adder_8bits_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_8bits_accum : sums BEATS {cout,sum} adder results, presents the|
// | total on valid/ready. Option: ACC_SATURATE_EN.  Revision 1.0         |
// +----------------------------------------------------------------------+
module adder_8bits_accum
  import accum_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int BEATS = 4,
  parameter int CNT_W = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  adder_8bits_accum_if.slave  bus
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_ovf;

  logic [ACC_W-1:0] w_beat;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_beat      = {{(ACC_W-BEAT_W){1'b0}}, bus.Acc_in_cout, bus.Acc_in_sum};
  assign w_accept    = bus.Acc_in_valid & r_in_ready;
  assign w_count_nxt = r_count + 1'b1;

  acc_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .i_a     (r_acc),
    .i_b     (w_beat),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ovf       <= 1'b0;
    end else if (bus.Acc_clear) begin
      // out_data deliberately keeps the last delivered total
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            if (w_carry) begin
              r_ovf <= 1'b1;
            end
            if (w_count_nxt == CNT_W'(BEATS)) begin
              r_state     <= ST_DONE;
              r_out_data  <= w_sum;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (bus.Acc_out_ready) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign bus.Acc_in_ready  = r_in_ready;
  assign bus.Acc_out_valid = r_out_valid;
  assign bus.Acc_out_data  = r_out_data;
  assign bus.Acc_out_ovf   = r_ovf;
  assign bus.Acc_count     = r_count;

endmodule
`default_nettype wire
